// File: rtl/fault_list_sequencer.sv
// -----------------------------------------------------------------------------
// fault_list_sequencer
//
// Walks the fault-injection list on behalf of the BIST controller. Each fault
// point (site index plus stuck-at polarity) is presented to the injection muxes
// around the CUT. Every change of point is followed by a settle window with
// injection disabled. FIL_END is raised once the list is exhausted.
//
// Configuration macro:
//   FIL_BOTH_POLARITY_EN  defined   : SA0 then SA1 per site (2*NUM_FAULTS points)
//                         undefined : SA0 only, FAULT_SA tied low (NUM_FAULTS points)
//
// Parameters:
//   NUM_FAULTS    number of fault sites (>= 2)
//   IDX_BITS      width of FAULT_IDX, 2**IDX_BITS >= NUM_FAULTS
//   SETTLE_CYCLES cycles FAULT_EN stays low after a point change (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   TPG_RESET  low level releases the sequencer from IDLE
//   FIL_INC    advance request, rising edge only
//   FAULT_IDX  current fault site
//   FAULT_SA   stuck-at value of current site (0 = SA0, 1 = SA1)
//   FAULT_EN   inject enable, high only in ACTIVE
//   FIL_BUSY   high in SETTLE or ACTIVE
//   FIL_END    list exhausted, sticky until rst
//
// State table:
//   IDLE   | waiting for TPG_RESET low
//   SETTLE | point changed, injection held off for SETTLE_CYCLES
//   ACTIVE | fault injected, waiting for FIL_INC edge
//   DONE   | list exhausted, terminal until rst
// -----------------------------------------------------------------------------
module fault_list_sequencer #(
    parameter int NUM_FAULTS    = 16,
    parameter int IDX_BITS      = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                TPG_RESET,
    input  logic                FIL_INC,
    output logic [IDX_BITS-1:0] FAULT_IDX,
    output logic                FAULT_SA,
    output logic                FAULT_EN,
    output logic                FIL_BUSY,
    output logic                FIL_END
);

    localparam int CNT_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] SETTLE_LOAD = CNT_BITS'(SETTLE_CYCLES - 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX    = IDX_BITS'(NUM_FAULTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_nx;
    logic [IDX_BITS-1:0] idx_nx;
    logic                inc_q;
    logic                adv;
    logic                at_last;

    // Only the rising edge of FIL_INC advances; a held level is one request.
    assign adv = FIL_INC & ~inc_q;

`ifdef FIL_BOTH_POLARITY_EN
    logic sa_nx;
    assign at_last = (FAULT_IDX == LAST_IDX) && FAULT_SA;
`else
    assign at_last = (FAULT_IDX == LAST_IDX);
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = FAULT_IDX;
`ifdef FIL_BOTH_POLARITY_EN
        sa_nx    = FAULT_SA;
`endif
        case (state)
            S_IDLE: begin
                if (!TPG_RESET) begin
                    state_nx = S_SETTLE;
                    cnt_nx   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                // Advance requests here are dropped, not queued.
                if (cnt == '0) begin
                    state_nx = S_ACTIVE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (adv) begin
                    if (at_last) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_SETTLE;
                        cnt_nx   = SETTLE_LOAD;
`ifdef FIL_BOTH_POLARITY_EN
                        if (!FAULT_SA) begin
                            sa_nx = 1'b1;
                        end else begin
                            sa_nx  = 1'b0;
                            idx_nx = FAULT_IDX + 1'b1;
                        end
`else
                        idx_nx = FAULT_IDX + 1'b1;
`endif
                    end
                end
            end
            S_DONE: begin
                state_nx = S_DONE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe and never see an input combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            inc_q     <= 1'b0;
            FAULT_IDX <= '0;
            FAULT_SA  <= 1'b0;
            FAULT_EN  <= 1'b0;
            FIL_BUSY  <= 1'b0;
            FIL_END   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            inc_q     <= FIL_INC;
            FAULT_IDX <= idx_nx;
`ifdef FIL_BOTH_POLARITY_EN
            FAULT_SA  <= sa_nx;
`else
            FAULT_SA  <= 1'b0;
`endif
            FAULT_EN  <= (state_nx == S_ACTIVE);
            FIL_BUSY  <= (state_nx == S_SETTLE) || (state_nx == S_ACTIVE);
            FIL_END   <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_fault_list_sequencer.sv
module tb_fault_list_sequencer;

    localparam int NF = 4;
    localparam int IB = 2;
    localparam int SC = 2;
`ifdef FIL_BOTH_POLARITY_EN
    localparam int NPTS = 2 * NF;
`else
    localparam int NPTS = NF;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tpg_reset = 1'b1;
    logic          fil_inc = 1'b0;
    logic [IB-1:0] fault_idx;
    logic          fault_sa;
    logic          fault_en;
    logic          fil_busy;
    logic          fil_end;

    fault_list_sequencer #(
        .NUM_FAULTS(NF),
        .IDX_BITS(IB),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .TPG_RESET(tpg_reset),
        .FIL_INC(fil_inc),
        .FAULT_IDX(fault_idx),
        .FAULT_SA(fault_sa),
        .FAULT_EN(fault_en),
        .FIL_BUSY(fil_busy),
        .FIL_END(fil_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_end;
        int idx;
        int sa;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   pos   = 0;

    // Reference list: point k of the fault list.
    function automatic int pt_idx(input int k);
`ifdef FIL_BOTH_POLARITY_EN
        return k / 2;
`else
        return k;
`endif
    endfunction

    function automatic int pt_sa(input int k);
`ifdef FIL_BOTH_POLARITY_EN
        return k % 2;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_point(input int k);
        exp_t e;
        e.is_end = 1'b0;
        e.idx    = pt_idx(k);
        e.sa     = pt_sa(k);
        sb.push_back(e);
    endtask

    // Monitor: pops an expectation on every new injection or on FIL_END rising,
    // and checks the settle window length in front of each injection.
    bit prev_en  = 1'b0;
    bit prev_end = 1'b0;
    int settle_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_en    = 1'b0;
            prev_end   = 1'b0;
            settle_cnt = 0;
        end else begin
            if (fil_busy && !fault_en) settle_cnt++;
            if (fault_en && !prev_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_activation", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("act_is_point", 0, int'(e.is_end));
                    chk("act_idx", int'(fault_idx), e.idx);
                    chk("act_sa", int'(fault_sa), e.sa);
                    chk("act_settle_len", settle_cnt, SC);
                    chk("act_busy", int'(fil_busy), 1);
                end
                settle_cnt = 0;
            end
            if (fil_end && !prev_end) begin
                if (sb.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("end_expected", int'(e.is_end), 1);
                    chk("end_en_low", int'(fault_en), 0);
                    chk("end_busy_low", int'(fil_busy), 0);
                end
            end
            prev_en  = fault_en;
            prev_end = fil_end;
        end
    end

    task automatic wait_for(input bit want_end);
        bit hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (want_end ? fil_end : fault_en) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk(want_end ? "wait_end_timeout" : "wait_active_timeout", 0, 1);
    endtask

    // Issue one advance: FIL_INC high for w cycles. With w==1 and extra set, a
    // second rising edge is placed inside the settle window and must be dropped.
    task automatic advance(input int w, input bit extra);
        exp_t e;
        if (pos == NPTS - 1) begin
            e.is_end = 1'b1;
            e.idx    = 0;
            e.sa     = 0;
            sb.push_back(e);
        end else begin
            push_point(pos + 1);
        end
        pos++;
        fil_inc = 1'b1;
        repeat (w) begin
            @(negedge clk); #1;
        end
        fil_inc = 1'b0;
        if (w == 1 && extra) begin
            @(negedge clk); #1;
            fil_inc = 1'b1;
            @(negedge clk); #1;
            fil_inc = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idx"},  int'(fault_idx), 0);
        chk({tag, "_sa"},   int'(fault_sa), 0);
        chk({tag, "_en"},   int'(fault_en), 0);
        chk({tag, "_busy"}, int'(fil_busy), 0);
        chk({tag, "_end"},  int'(fil_end), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // TPG_RESET still high: must stay in IDLE.
        repeat (2) begin
            @(negedge clk); #1;
        end
        chk("idle_hold_busy", int'(fil_busy), 0);

        // Release: SETTLE after one edge, FAULT_EN after SETTLE_CYCLES more.
        push_point(0);
        pos = 0;
        tpg_reset = 1'b0;
        @(negedge clk); #1;
        chk("release_busy", int'(fil_busy), 1);
        chk("release_en_low", int'(fault_en), 0);
        repeat (SC) begin
            @(negedge clk); #1;
        end
        chk("release_en", int'(fault_en), 1);
        chk("release_idx", int'(fault_idx), 0);
        chk("release_sa", int'(fault_sa), 0);
        chk("release_end", int'(fil_end), 0);
        tpg_reset = 1'b1;

        // Held advance: five cycles high is a single request.
        advance(5, 1'b0);
        wait_for(1'b0);
        repeat (2) begin
            @(negedge clk); #1;
        end
        chk("held_idx", int'(fault_idx), pt_idx(1));
        chk("held_sa", int'(fault_sa), pt_sa(1));
        chk("held_en", int'(fault_en), 1);

        // Second edge inside the settle window is dropped.
        advance(1, 1'b1);
        wait_for(1'b0);
        repeat (3) begin
            @(negedge clk); #1;
        end
        chk("drop_idx", int'(fault_idx), pt_idx(2));
        chk("drop_sa", int'(fault_sa), pt_sa(2));

        // Random walk up to site 2.
        while (pt_idx(pos) != 2) begin
            advance($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            wait_for(1'b0);
            tpg_reset = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk); #1;
            end
        end
        chk("pre_rst_en", int'(fault_en), 1);
        chk("pre_rst_idx", int'(fault_idx), 2);
        chk("pre_rst_sb_empty", sb.size(), 0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        fil_inc = 1'b0;
        tpg_reset = 1'b1;
        sb.delete();
        repeat (2) begin
            @(negedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_idle_busy", int'(fil_busy), 0);
        push_point(0);
        pos = 0;
        tpg_reset = 1'b0;
        wait_for(1'b0);
        chk("restart_idx", int'(fault_idx), 0);
        chk("restart_sa", int'(fault_sa), 0);

        // Full walk with randomized pulse widths, gaps and settle-window noise.
        for (int i = 0; i < NPTS; i++) begin
            advance($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            if (pos == NPTS) begin
                wait_for(1'b1);
            end else begin
                wait_for(1'b0);
                tpg_reset = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk); #1;
                end
            end
        end
        @(negedge clk); #1;
        chk("done_end", int'(fil_end), 1);
        chk("done_en", int'(fault_en), 0);
        chk("done_busy", int'(fil_busy), 0);
        chk("done_idx", int'(fault_idx), NF - 1);
        chk("done_sa", int'(fault_sa), pt_sa(NPTS - 1));

        // Extra pulse and TPG_RESET activity after the end change nothing.
        tpg_reset = 1'b0;
        fil_inc = 1'b1;
        @(negedge clk); #1;
        fil_inc = 1'b0;
        tpg_reset = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
        end
        chk("extra_end", int'(fil_end), 1);
        chk("extra_en", int'(fault_en), 0);
        chk("extra_busy", int'(fil_busy), 0);
        chk("extra_idx", int'(fault_idx), NF - 1);
        chk("extra_sa", int'(fault_sa), pt_sa(NPTS - 1));
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fault_list_sequencer.md
Name: fault_list_sequencer

Overview:
- Fault-injection list (FIL) sequencer; responder for the BIST controller's FIL_INC / TPG_RESET outputs.
- Walks the fault list and drives fault site index, stuck-at value and inject enable to the fault-injection muxes around the CUT.
- Returns FIL_END to the controller when the list is exhausted.

Parameters:
- NUM_FAULTS, 16, number of fault sites in the list (≥2).
- IDX_BITS, 4, width of FAULT_IDX; must satisfy 2^IDX_BITS ≥ NUM_FAULTS.
- SETTLE_CYCLES, 2, cycles FAULT_EN stays low after any change of site/polarity before injection (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- TPG_RESET  in  1  controller's TPG reset; a low level releases the sequencer from IDLE.
- FIL_INC  in  1  advance request from controller; level may persist several cycles, so only the rising edge counts.
- FAULT_IDX  out  IDX_BITS  current fault site.
- FAULT_SA  out  1  stuck-at value for the current site (0 = SA0, 1 = SA1).
- FAULT_EN  out  1  inject enable; high only in ACTIVE.
- FIL_BUSY  out  1  high in SETTLE or ACTIVE.
- FIL_END  out  1  list exhausted; sticky until rst.

Behaviour:
- Reset state (async, immediate): IDLE, FAULT_IDX=0, FAULT_SA=0, FAULT_EN=0, FIL_BUSY=0, FIL_END=0, settle counter=0, edge register=0.
- Edge detect: inc_q registers FIL_INC every cycle; adv = FIL_INC & ~inc_q. A level held N cycles produces exactly one adv.
- IDLE:
  - First clock edge with TPG_RESET=0 goes to SETTLE and loads the settle counter with SETTLE_CYCLES-1.
  - adv is ignored in IDLE.
- SETTLE:
  - FAULT_EN=0 and FIL_BUSY=1.
  - Counter decrements each cycle; at 0 the next state is ACTIVE.
  - Time from SETTLE entry to FAULT_EN=1 is exactly SETTLE_CYCLES cycles.
  - adv in SETTLE is discarded, not queued.
- ACTIVE:
  - FAULT_EN=1 and FIL_BUSY=1.
  - TPG_RESET has no effect here; the controller pulses it per fault.
  - On adv with the current point not last: FAULT_EN drops on the next cycle, then go to SETTLE and reload the counter.
    - If FAULT_SA=0, set FAULT_SA=1 and keep FAULT_IDX.
    - If FAULT_SA=1, set FAULT_SA=0 and FAULT_IDX+1.
  - Last point is FAULT_IDX=NUM_FAULTS-1 with FAULT_SA=1. On adv at the last point go to DONE; FAULT_IDX and FAULT_SA hold their final values.
- DONE:
  - FIL_END=1, FAULT_EN=0, FIL_BUSY=0.
  - All inputs are ignored; only rst exits.
- FAULT_IDX never exceeds NUM_FAULTS-1. No wrap-around; DONE is terminal.
- rst mid-operation: every output returns to its reset value on the same edge, with no glitch-free requirement.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: FIL_BOTH_POLARITY_EN.
- Defined: SA0 then SA1 per site, as specified above; 2·NUM_FAULTS fault points.
- Undefined:
  - FAULT_SA is tied to 0.
  - Every adv increments FAULT_IDX.
  - Last point is FAULT_IDX=NUM_FAULTS-1; NUM_FAULTS fault points.

Test Plan (NUM_FAULTS=4, SETTLE_CYCLES=2, macro defined unless stated):
- Release: rst high 3 cycles, then low, TPG_RESET low at cycle 0 -> SETTLE at cycle 1, FAULT_EN=1 at cycle 3, FAULT_IDX=0, FAULT_SA=0, FIL_END=0.
- Held advance: FIL_INC held high 5 cycles in ACTIVE -> exactly one advance, FAULT_IDX=0, FAULT_SA=1, FAULT_EN low for 2 cycles then high.
- Full walk: 8 separated FIL_INC pulses -> sequence (0,0),(0,1),(1,0),…,(3,1), then FIL_END=1, FAULT_EN=0; a 9th pulse causes no change.
- Settle drop: FIL_INC pulse during SETTLE -> ignored; FAULT_IDX/FAULT_SA unchanged; ACTIVE entered on schedule.
- Async reset mid-ACTIVE at FAULT_IDX=2: assert rst between clock edges -> outputs read 0 immediately, state IDLE; after release, restart from (0,0).
- Macro undefined: 4 pulses -> FAULT_IDX 0→1→2→3, FAULT_SA constantly 0, FIL_END=1 after the 4th pulse.
